// File: rtl/soda_controller.sv
// Coin-operated soda vending controller: accumulates nickel/dime/quarter credit,
// requests a can once PRICE is reached, then returns change or refunds on cancel/timeout.
module soda_controller #(
    parameter int PRICE   = 15,
    parameter int TIMEOUT = 255
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Nickel,
    input  logic       Dime,
    input  logic       Quarter,
    input  logic       Cancel,
    input  logic       DispAck,
    output logic       Dispense,
    output logic [5:0] Change,
    output logic       ChangeValid,
    output logic [5:0] Credit,
    output logic       CoinReject,
    output logic       Busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE,
        ST_CHANGE,
        ST_REFUND
    } state_t;

    localparam logic [5:0] PRICE_C    = 6'(PRICE);
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] idle_cnt;
    logic [5:0] coin_val;
    logic [5:0] sum;
    logic       any_coin;
    logic       multi_coin;
    logic       one_coin;
    logic       in_collect;
    logic       go_refund;

    assign any_coin   = Nickel | Dime | Quarter;
    assign multi_coin = (Nickel & Dime) | (Nickel & Quarter) | (Dime & Quarter);
    assign one_coin   = any_coin & ~multi_coin;
    assign in_collect = (state == ST_COLLECT);

    // Cancel beats a simultaneous coin; timeout only fires on a cycle with no accepted coin.
    assign go_refund = in_collect & (Cancel | (~one_coin & (idle_cnt == IDLE_LIMIT)));

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        coin_val = 6'd0;
        if (Nickel)  coin_val = 6'd5;
        if (Dime)    coin_val = 6'd10;
        if (Quarter) coin_val = 6'd25;
    end

    assign sum  = Credit + coin_val;
    assign Busy = (state == ST_DISPENSE) || (state == ST_CHANGE) || (state == ST_REFUND);

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    // NOTE: only control/data registers exist here; every one is async-reset so Rst alone restores a clean IDLE.
    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            idle_cnt    <= 8'd0;
            Credit      <= 6'd0;
            Change      <= 6'd0;
            ChangeValid <= 1'b0;
            Dispense    <= 1'b0;
            CoinReject  <= 1'b0;
        end else begin
            ChangeValid <= 1'b0;
            CoinReject  <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (go_refund) begin
                        state       <= ST_REFUND;
                        idle_cnt    <= 8'd0;
                        ChangeValid <= 1'b1;
                        Change      <= Credit;
                        CoinReject  <= any_coin;
                    end else if (one_coin) begin
                        Credit   <= sum;
                        idle_cnt <= 8'd0;
                        if (sum >= PRICE_C) begin
                            state    <= ST_DISPENSE;
                            Dispense <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else begin
                        CoinReject <= multi_coin;
                        if (in_collect) idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                ST_DISPENSE: begin
                    CoinReject <= any_coin;
                    if (DispAck) begin
                        Dispense <= 1'b0;
                        if (Credit > PRICE_C) begin
                            state       <= ST_CHANGE;
                            ChangeValid <= 1'b1;
                            Change      <= Credit - PRICE_C;
                        end else begin
                            state  <= ST_IDLE;
                            Credit <= 6'd0;
                        end
                    end
                end
                ST_CHANGE, ST_REFUND: begin
                    CoinReject <= any_coin;
                    state      <= ST_IDLE;
                    Credit     <= 6'd0;
                    Change     <= 6'd0;
                end
                default: begin
                    state    <= ST_IDLE;
                    idle_cnt <= 8'd0;
                    Credit   <= 6'd0;
                    Change   <= 6'd0;
                    Dispense <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soda_controller.sv
// Directed bench for soda_controller (PRICE=15, TIMEOUT=4); inputs change just after
// the falling edge, outputs are sampled 1ns after it.
module tb_soda_controller;

    logic       Clk = 1'b1;
    logic       Rst = 1'b1;
    logic       Nickel = 1'b0, Dime = 1'b0, Quarter = 1'b0, Cancel = 1'b0, DispAck = 1'b0;
    logic       Dispense, ChangeValid, CoinReject, Busy;
    logic [5:0] Change, Credit;

    int n_checks = 0;
    int n_errors = 0;

    soda_controller #(.PRICE(15), .TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst), .Nickel(Nickel), .Dime(Dime), .Quarter(Quarter),
        .Cancel(Cancel), .DispAck(DispAck), .Dispense(Dispense), .Change(Change),
        .ChangeValid(ChangeValid), .Credit(Credit), .CoinReject(CoinReject), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Apply one cycle of inputs across a falling edge, then release them.
    task automatic step(input logic n, input logic d, input logic q, input logic c, input logic a);
        Nickel = n; Dime = d; Quarter = q; Cancel = c; DispAck = a;
        @(negedge Clk);
        #1;
        Nickel = 0; Dime = 0; Quarter = 0; Cancel = 0; DispAck = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, 8'(Credit), 8'd0);
        check({tag, "_change"}, 8'(Change), 8'd0);
        check({tag, "_cv"}, 8'(ChangeValid), 8'd0);
        check({tag, "_disp"}, 8'(Dispense), 8'd0);
        check({tag, "_rej"}, 8'(CoinReject), 8'd0);
        check({tag, "_busy"}, 8'(Busy), 8'd0);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 Rst = 0;
        #1 check_all_zero("reset");
        @(negedge Clk); #1;
        Rst = 1;
        step(0, 0, 0, 0, 0);
        check_all_zero("post_reset");

        // Dime then Nickel: exact price, no change
        step(0, 1, 0, 0, 0);
        check("t1_credit10", 8'(Credit), 8'd10);
        check("t1_nodisp", 8'(Dispense), 8'd0);
        step(1, 0, 0, 0, 0);
        check("t1_credit15", 8'(Credit), 8'd15);
        check("t1_disp", 8'(Dispense), 8'd1);
        check("t1_busy", 8'(Busy), 8'd1);
        step(0, 0, 0, 0, 0);
        check("t1_disp_held", 8'(Dispense), 8'd1);
        step(0, 0, 0, 0, 1);
        check("t1_ack_disp", 8'(Dispense), 8'd0);
        check("t1_ack_credit", 8'(Credit), 8'd0);
        check("t1_ack_cv", 8'(ChangeValid), 8'd0);
        check("t1_ack_busy", 8'(Busy), 8'd0);

        // Dime, Quarter: 35 cents, late ack, coin rejected while dispensing, change 20
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t2_credit35", 8'(Credit), 8'd35);
        check("t2_disp", 8'(Dispense), 8'd1);
        step(1, 0, 0, 0, 0);
        check("t2_rej_disp", 8'(CoinReject), 8'd1);
        check("t2_rej_credit", 8'(Credit), 8'd35);
        step(0, 0, 0, 0, 0);
        check("t2_rej_clear", 8'(CoinReject), 8'd0);
        step(0, 0, 0, 0, 0);
        check("t2_disp_held3", 8'(Dispense), 8'd1);
        step(0, 0, 0, 0, 1);
        check("t2_ack_disp", 8'(Dispense), 8'd0);
        check("t2_cv", 8'(ChangeValid), 8'd1);
        check("t2_change", 8'(Change), 8'd20);
        check("t2_busy", 8'(Busy), 8'd1);
        step(0, 0, 0, 0, 0);
        check("t2_cv_end", 8'(ChangeValid), 8'd0);
        check("t2_change_end", 8'(Change), 8'd0);
        check("t2_credit_end", 8'(Credit), 8'd0);
        check("t2_busy_end", 8'(Busy), 8'd0);

        // Two coins at once from IDLE, then Cancel in IDLE ignored
        step(1, 1, 0, 0, 0);
        check("t3_multi_rej", 8'(CoinReject), 8'd1);
        check("t3_multi_credit", 8'(Credit), 8'd0);
        check("t3_multi_busy", 8'(Busy), 8'd0);
        step(0, 0, 0, 1, 0);
        check("t3_rej_clear", 8'(CoinReject), 8'd0);
        check("t3_cancel_idle_cv", 8'(ChangeValid), 8'd0);
        check("t3_cancel_idle_busy", 8'(Busy), 8'd0);

        // Cancel + Nickel in COLLECT with 10 cents: refund 10, coin rejected
        step(0, 1, 0, 0, 0);
        check("t3_credit10", 8'(Credit), 8'd10);
        step(1, 0, 0, 1, 0);
        check("t3_refund_cv", 8'(ChangeValid), 8'd1);
        check("t3_refund_change", 8'(Change), 8'd10);
        check("t3_refund_rej", 8'(CoinReject), 8'd1);
        check("t3_refund_busy", 8'(Busy), 8'd1);
        step(0, 0, 0, 0, 0);
        check("t3_after_cv", 8'(ChangeValid), 8'd0);
        check("t3_after_credit", 8'(Credit), 8'd0);
        check("t3_after_busy", 8'(Busy), 8'd0);

        // Timeout: Nickel, then 4 idle cycles (a stray DispAck on the first is ignored)
        step(1, 0, 0, 0, 0);
        check("t4_credit5", 8'(Credit), 8'd5);
        step(0, 0, 0, 0, 1);
        check("t4_ack_ignored_credit", 8'(Credit), 8'd5);
        check("t4_ack_ignored_busy", 8'(Busy), 8'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t4_idle3_cv", 8'(ChangeValid), 8'd0);
        step(0, 0, 0, 0, 0);
        check("t4_timeout_cv", 8'(ChangeValid), 8'd1);
        check("t4_timeout_change", 8'(Change), 8'd5);
        step(0, 0, 0, 0, 0);
        check("t4_end_cv", 8'(ChangeValid), 8'd0);
        check("t4_end_credit", 8'(Credit), 8'd0);
        check("t4_end_busy", 8'(Busy), 8'd0);

        // Reset mid-DISPENSE with 35 cents, then normal operation resumes
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t5_credit35", 8'(Credit), 8'd35);
        check("t5_disp", 8'(Dispense), 8'd1);
        #2 Rst = 0;
        #1 check_all_zero("t5_async");
        #1 Rst = 1;
        step(0, 0, 1, 0, 0);
        check("t5_quarter_credit", 8'(Credit), 8'd25);
        check("t5_quarter_disp", 8'(Dispense), 8'd1);
        step(0, 0, 0, 0, 1);
        check("t5_change_cv", 8'(ChangeValid), 8'd1);
        check("t5_change_val", 8'(Change), 8'd10);
        step(0, 0, 0, 0, 0);
        check_all_zero("t5_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
